uart_wb_loader: RTL

//  Wishbone initiator that acts as the bus-side consumer of the Amber UART. It polls the UART

---
 rtl/uart_wb_loader.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_wb_loader.sv
// uart_wb_loader: Wishbone initiator that drains the Amber UART RX FIFO and
// writes the received bytes to memory as little-endian 32-bit words.
// Build option: define AMBER_LOADER_ECHO_EN to echo every received byte back
// through the UART TX FIFO before it is committed.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for i_start; count==0 start pulses o_done directly
// POLL_FR  | reading the UART flag register until RX FIFO is non-empty
// READ_DR  | popping one byte from the UART data register
// ECHO_FR  | (echo build) reading the flag register until TX FIFO has room
// ECHO_WR  | (echo build) pushing the last received byte into the TX FIFO
// MEM_WR   | writing the assembled word to the current memory address
// DONE     | one-cycle completion pulse
// ERROR    | bus error seen; cycle dropped, back to IDLE next clock

module uart_wb_loader #(
  parameter logic [31:0] UART_BASE = 32'h1600_0000,
  parameter logic [15:0] DR_OFFSET = 16'h0000,
  parameter logic [15:0] FR_OFFSET = 16'h0018
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_load_adr,
  input  logic [15:0] i_word_count,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [15:0] o_words_loaded,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_dat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic        i_wb_ack,
  input  logic        i_wb_err
);

  localparam logic [31:0] DR_ADR = UART_BASE + {16'h0000, DR_OFFSET};
  localparam logic [31:0] FR_ADR = UART_BASE + {16'h0000, FR_OFFSET};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_POLL_FR = 3'd1,
    S_READ_DR = 3'd2,
    S_MEM_WR  = 3'd3,
    S_DONE    = 3'd4,
`ifdef AMBER_LOADER_ECHO_EN
    S_ECHO_FR = 3'd6,
    S_ECHO_WR = 3'd7,
`endif
    S_ERROR   = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [29:0] word_adr;
  logic [15:0] word_count;
  logic [1:0]  byte_idx;
  logic [31:0] word_buf;
  logic        zero_done;
  logic        xfer_ok;
  logic        last_word;
`ifdef AMBER_LOADER_ECHO_EN
  logic [7:0]  last_byte;
`endif

  // Bits of the inputs the loader never looks at.
  logic unused_bits;
  assign unused_bits = ^{i_wb_dat[31:8], i_load_adr[1:0]};

  // Error takes priority over a simultaneous acknowledge.
  assign xfer_ok   = i_wb_ack && !i_wb_err;
  assign last_word = (o_words_loaded + 16'd1) == word_count;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; a bus error in any bus state aborts the load.
  always_comb begin
    state_nxt = state;
    if (o_wb_cyc && i_wb_err) begin
      state_nxt = S_ERROR;
    end else begin
      case (state)
        S_IDLE:    if (i_start && (i_word_count != 16'd0)) state_nxt = S_POLL_FR;
        S_POLL_FR: if (xfer_ok) state_nxt = i_wb_dat[4] ? S_POLL_FR : S_READ_DR;
`ifdef AMBER_LOADER_ECHO_EN
        S_READ_DR: if (xfer_ok) state_nxt = S_ECHO_FR;
        S_ECHO_FR: if (xfer_ok) state_nxt = i_wb_dat[5] ? S_ECHO_FR : S_ECHO_WR;
        // byte_idx has already advanced, so 0 here means the word is full.
        S_ECHO_WR: if (xfer_ok) state_nxt = (byte_idx == 2'd0) ? S_MEM_WR : S_POLL_FR;
`else
        S_READ_DR: if (xfer_ok) state_nxt = (byte_idx == 2'd3) ? S_MEM_WR : S_POLL_FR;
`endif
        S_MEM_WR:  if (xfer_ok) state_nxt = last_word ? S_DONE : S_POLL_FR;
        S_DONE:    state_nxt = S_IDLE;
        S_ERROR:   state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Bus and status outputs decoded from the current state.
  always_comb begin
    o_wb_cyc = 1'b0;
    o_wb_we  = 1'b0;
    o_wb_adr = 32'h0;
    o_wb_dat = 32'h0;
    case (state)
      S_POLL_FR: begin
        o_wb_cyc = 1'b1;
        o_wb_adr = FR_ADR;
      end
      S_READ_DR: begin
        o_wb_cyc = 1'b1;
        o_wb_adr = DR_ADR;
      end
`ifdef AMBER_LOADER_ECHO_EN
      S_ECHO_FR: begin
        o_wb_cyc = 1'b1;
        o_wb_adr = FR_ADR;
      end
      S_ECHO_WR: begin
        o_wb_cyc = 1'b1;
        o_wb_we  = 1'b1;
        o_wb_adr = DR_ADR;
        o_wb_dat = {24'h0, last_byte};
      end
`endif
      S_MEM_WR: begin
        o_wb_cyc = 1'b1;
        o_wb_we  = 1'b1;
        o_wb_adr = {word_adr, 2'b00};
        o_wb_dat = word_buf;
      end
      default: ;
    endcase
  end

  assign o_wb_stb = o_wb_cyc;
  assign o_wb_sel = o_wb_cyc ? 4'hf : 4'h0;
  assign o_busy   = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
  assign o_done   = (state == S_DONE) || zero_done;

  // Datapath: latch the job, assemble bytes, advance address and counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      word_adr       <= 30'h0;
      word_count     <= 16'h0;
      byte_idx       <= 2'd0;
      word_buf       <= 32'h0;
      zero_done      <= 1'b0;
      o_error        <= 1'b0;
      o_words_loaded <= 16'h0;
`ifdef AMBER_LOADER_ECHO_EN
      last_byte      <= 8'h0;
`endif
    end else begin
      zero_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            o_error <= 1'b0;
            if (i_word_count == 16'd0) begin
              zero_done <= 1'b1;
            end else begin
              word_adr       <= i_load_adr[31:2];
              word_count     <= i_word_count;
              byte_idx       <= 2'd0;
              word_buf       <= 32'h0;
              o_words_loaded <= 16'h0;
            end
          end
        end
        S_READ_DR: begin
          if (xfer_ok) begin
            word_buf[8*byte_idx +: 8] <= i_wb_dat[7:0];
            byte_idx                  <= byte_idx + 2'd1;
`ifdef AMBER_LOADER_ECHO_EN
            last_byte                 <= i_wb_dat[7:0];
`endif
          end
        end
        S_MEM_WR: begin
          if (xfer_ok) begin
            word_adr       <= word_adr + 30'd1;
            o_words_loaded <= o_words_loaded + 16'd1;
            byte_idx       <= 2'd0;
          end
        end
        default: ;
      endcase
      if (o_wb_cyc && i_wb_err) o_error <= 1'b1;
    end
  end

endmodule
